// File: rtl/riscv_pkg.sv
// Shared load/store encodings and the memory-stage FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  // Undefined store encodings behave as SW; undefined load encodings read a full word.
  function automatic acc_size_t decode_size(input logic [2:0] f3, input logic is_store);
    acc_size_t sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction
// with sign/zero extension, and misalignment detection. No state, no handshake.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        i_access,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  acc_size_t   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    w_size     = decode_size(i_funct3, i_is_store);
    o_misalign = i_access & (((w_size == SZ_H) & i_addr_lo[0]) |
                             ((w_size == SZ_W) & (i_addr_lo != 2'b00)));

    o_be    = 4'b1111;
    o_wdata = i_wdata;
    if (i_is_store) begin
      case (w_size)
        SZ_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        SZ_H: begin
          o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    // funct3[2] marks the unsigned variants (LBU/LHU).
    w_sext = ~i_funct3[2];
    case (w_size)
      SZ_B:    o_rdata = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_H:    o_rdata = {{16{w_sext & w_half[15]}}, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V MEM stage: zero-wait accesses complete in the issue cycle; otherwise StallM
// freezes upstream until dmem_ready or a MAX_WAIT watchdog abort (sticky BusErrorM).
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrorM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW
);

  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [7:0]  w_wait_inc;
  logic        r_bus_err;

  logic        w_access;
  logic        w_misalign;
  logic        w_req;
  logic        w_abort;
  logic        w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  logic [31:0] r_alu_result_w;
  logic [31:0] r_read_data_w;
  logic [31:0] r_pc_plus4_w;
  logic [4:0]  r_rd_w;
  logic        r_reg_write_w;
  logic [1:0]  r_result_src_w;

  assign w_access = MemReadM | MemWriteM;

  lsu_align u_lsu_align (
    .i_access   (w_access),
    .i_is_store (MemWriteM),
    .i_funct3   (Funct3M),
    .i_addr_lo  (ALUResultM[1:0]),
    .i_wdata    (WriteDataM),
    .i_rdata    (dmem_rdata),
    .o_misalign (w_misalign),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_req          = 1'b0;
    w_abort        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access & ~w_misalign) begin
          w_req = 1'b1;
          if (!dmem_ready) begin
            w_state_nxt    = BUSY;
            w_wait_cnt_nxt = 8'd0;
          end
        end
      end
      BUSY: begin
        w_req          = 1'b1;
        w_wait_cnt_nxt = w_wait_inc;
        if (dmem_ready) begin
          w_state_nxt = IDLE;
        end else if (w_wait_inc >= MAX_WAIT_L) begin
          // The cycle that would have been wait number MAX_WAIT+1 becomes the abort.
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) begin
      w_req   = 1'b0;
      w_abort = 1'b0;
    end
  end

  assign w_stall    = w_req & ~dmem_ready & ~w_abort;

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & MemWriteM;
  assign dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem_be    = w_be;
  assign dmem_wdata = w_wdata;
  assign StallM     = w_stall;
  assign MisalignM  = w_misalign;
  assign BusErrorM  = r_bus_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_abort) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_result_w <= 32'd0;
      r_read_data_w  <= 32'd0;
      r_pc_plus4_w   <= 32'd0;
      r_rd_w         <= 5'd0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 2'd0;
    end else if (w_stall) begin
      r_rd_w        <= 5'd0;
      r_reg_write_w <= 1'b0;
    end else begin
      r_alu_result_w <= ALUResultM;
      r_read_data_w  <= (w_req & dmem_ready & ~MemWriteM) ? w_load_data : 32'd0;
      r_pc_plus4_w   <= PCPlus4M;
      r_rd_w         <= RdM;
      r_reg_write_w  <= RegWriteM & ~w_misalign & ~w_abort;
      r_result_src_w <= ResultSrcM;
    end
  end

  assign ALUResultW = r_alu_result_w;
  assign ReadDataW  = r_read_data_w;
  assign PCPlus4W   = r_pc_plus4_w;
  assign RdW        = r_rd_w;
  assign RegWriteW  = r_reg_write_w;
  assign ResultSrcW = r_result_src_w;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, waited loads, misalign, watchdog abort, reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, MemReadM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, MisalignM, BusErrorM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrorM(BusErrorM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
    ResultSrcM = '0; Funct3M = '0; dmem_ready = 1'b0; dmem_rdata = '0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic rw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd_idx);
    MemReadM = rd_en; MemWriteM = wr_en; RegWriteM = rw; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wdata; RdM = rd_idx;
    PCPlus4M = addr + 32'd4; ResultSrcM = rd_en ? 2'b01 : 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd3);
    #2;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_cmp++; if (StallM !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", StallM); end
    step();
    n_cmp++; if (ALUResultW !== 32'h0 || ReadDataW !== 32'h0 || PCPlus4W !== 32'h0)
      begin n_err++; $display("FAIL reset_wdata: got %h/%h/%h want 0", ALUResultW, ReadDataW, PCPlus4W); end
    n_cmp++; if (RdW !== 5'd0 || RegWriteW !== 1'b0 || ResultSrcW !== 2'd0 || BusErrorM !== 1'b0)
      begin n_err++; $display("FAIL reset_ctrl: got rd=%0d rw=%b rs=%0d be=%b want 0", RdW, RegWriteW, ResultSrcW, BusErrorM); end
    drive_nop();
    reset = 1'b0;
    step();
  endtask

  task automatic test_store();
    drive_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h103, 32'h000000AB, 5'd0);
    dmem_ready = 1'b1;
    #2;
    n_cmp++; if (dmem_be !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b want 1000", dmem_be); end
    n_cmp++; if (dmem_wdata !== 32'hABABABAB) begin n_err++; $display("FAIL sb_wdata: got %h want abababab", dmem_wdata); end
    n_cmp++; if (dmem_addr !== 32'h100 || dmem_req !== 1'b1 || dmem_we !== 1'b1)
      begin n_err++; $display("FAIL sb_req: got addr=%h req=%b we=%b want 100/1/1", dmem_addr, dmem_req, dmem_we); end
    n_cmp++; if (StallM !== 1'b0) begin n_err++; $display("FAIL sb_stall: got %b want 0", StallM); end
    step();
    n_cmp++; if (ALUResultW !== 32'h103 || PCPlus4W !== 32'h107)
      begin n_err++; $display("FAIL sb_wb: got %h/%h want 103/107", ALUResultW, PCPlus4W); end
    drive_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'hFFFF1234, 5'd0);
    #2;
    n_cmp++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h12341234)
      begin n_err++; $display("FAIL sh: got be=%b wdata=%h want 1100/12341234", dmem_be, dmem_wdata); end
    step();
    drive_op(1'b0, 1'b1, 1'b0, 3'b011, 32'h204, 32'hCAFEF00D, 5'd0);
    #2;
    n_cmp++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'hCAFEF00D)
      begin n_err++; $display("FAIL sw_other: got be=%b wdata=%h want 1111/cafef00d", dmem_be, dmem_wdata); end
    step();
    drive_nop();
  endtask

  task automatic test_load_wait(input logic [2:0] f3, input logic [31:0] exp);
    int stalls = 0;
    drive_op(1'b1, 1'b0, 1'b1, f3, 32'h102, 32'h0, 5'd5);
    dmem_ready = 1'b0;
    dmem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0080FF00;
      end
      #2;
      if (StallM) stalls++;
      if (c == 0) begin
        n_cmp++; if (dmem_be !== 4'b1111 || dmem_we !== 1'b0)
          begin n_err++; $display("FAIL load_be: got be=%b we=%b want 1111/0", dmem_be, dmem_we); end
      end
      step();
      if (c == 0) begin
        n_cmp++; if (RegWriteW !== 1'b0 || RdW !== 5'd0)
          begin n_err++; $display("FAIL load_bubble: got rw=%b rd=%0d want 0/0", RegWriteW, RdW); end
      end
    end
    n_cmp++; if (stalls !== 3) begin n_err++; $display("FAIL load_stall_cnt: got %0d want 3", stalls); end
    n_cmp++; if (ReadDataW !== exp) begin n_err++; $display("FAIL load_data f3=%b: got %h want %h", f3, ReadDataW, exp); end
    n_cmp++; if (RegWriteW !== 1'b1 || RdW !== 5'd5 || ResultSrcW !== 2'b01)
      begin n_err++; $display("FAIL load_ctrl: got rw=%b rd=%0d rs=%0d want 1/5/1", RegWriteW, RdW, ResultSrcW); end
    drive_nop();
  endtask

  task automatic test_misalign();
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd7);
    dmem_ready = 1'b1;
    #2;
    n_cmp++; if (MisalignM !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", MisalignM); end
    n_cmp++; if (dmem_req !== 1'b0 || StallM !== 1'b0)
      begin n_err++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_req, StallM); end
    step();
    n_cmp++; if (RegWriteW !== 1'b0 || RdW !== 5'd7 || ALUResultW !== 32'h102)
      begin n_err++; $display("FAIL mis_wb: got rw=%b rd=%0d alu=%h want 0/7/102", RegWriteW, RdW, ALUResultW); end
    drive_nop();
  endtask

  task automatic test_abort();
    int stalls = 0;
    bit done = 1'b0;
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 5'd8);
    dmem_ready = 1'b0;
    dmem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (StallM) stalls++;
      else done = 1'b1;
      if (!done) step();
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL abort_timeout: StallM still %b after 40 cycles, want release", StallM); end
    n_cmp++; if (stalls !== 15) begin n_err++; $display("FAIL abort_stall_cnt: got %0d want 15", stalls); end
    step();
    n_cmp++; if (BusErrorM !== 1'b1) begin n_err++; $display("FAIL abort_buserr: got %b want 1", BusErrorM); end
    n_cmp++; if (ReadDataW !== 32'h0 || RegWriteW !== 1'b0)
      begin n_err++; $display("FAIL abort_wb: got rdata=%h rw=%b want 0/0", ReadDataW, RegWriteW); end
    drive_nop();
    step();
    step();
    n_cmp++; if (BusErrorM !== 1'b1 || dmem_req !== 1'b0)
      begin n_err++; $display("FAIL abort_sticky: got be=%b req=%b want 1/0", BusErrorM, dmem_req); end
  endtask

  task automatic test_back_to_back();
    drive_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 5'd10);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80011234;
    #2;
    n_cmp++; if (StallM !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got %b want 0", StallM); end
    step();
    n_cmp++; if (ReadDataW !== 32'hFFFF8001 || RegWriteW !== 1'b1 || RdW !== 5'd10)
      begin n_err++; $display("FAIL b2b_lh: got %h rw=%b rd=%0d want ffff8001/1/10", ReadDataW, RegWriteW, RdW); end
    drive_nop();
    drive_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd9);
    #2;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL b2b_alu_req: got %b want 0", dmem_req); end
    step();
    n_cmp++; if (ALUResultW !== 32'h55 || RdW !== 5'd9 || RegWriteW !== 1'b1 || ResultSrcW !== 2'b00)
      begin n_err++; $display("FAIL b2b_alu_wb: got %h rd=%0d rw=%b rs=%0d want 55/9/1/0", ALUResultW, RdW, RegWriteW, ResultSrcW); end
    drive_nop();
  endtask

  task automatic test_reset_busy();
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 5'd11);
    dmem_ready = 1'b0;
    step();
    #1;
    n_cmp++; if (StallM !== 1'b1) begin n_err++; $display("FAIL rb_busy: got stall=%b want 1", StallM); end
    reset = 1'b1;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || StallM !== 1'b0)
      begin n_err++; $display("FAIL rb_req: got req=%b stall=%b want 0/0", dmem_req, StallM); end
    n_cmp++; if (RegWriteW !== 1'b0 || ALUResultW !== 32'h0 || BusErrorM !== 1'b0)
      begin n_err++; $display("FAIL rb_wb: got rw=%b alu=%h be=%b want 0/0/0", RegWriteW, ALUResultW, BusErrorM); end
    step();
    reset = 1'b0;
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 5'd12);
    #2;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rb_idle: got req=%b want 0", dmem_req); end
    step();
    drive_nop();
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    test_reset();
    test_store();
    test_load_wait(3'b000, 32'hFFFFFF80);
    test_load_wait(3'b100, 32'h00000080);
    test_misalign();
    test_abort();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
